// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a single-port RAM. It supports a bounded burst lock,
// blocks accesses above MEM_TOP, and returns read data one cycle after the grant.
module mem_arbiter #(
  parameter int unsigned       ADDR_W    = 12,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [ADDR_W-1:0] MEM_TOP   = 'h0df,
  parameter int unsigned       MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2} owner_t;

  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

  owner_t            owner_reg, owner_next, gnt_owner;
  logic [7:0]        burst_cnt_reg, burst_cnt_next;
  logic              rr_last_reg, rr_last_next;
  logic              rd_pend_reg, rd_pend_next;
  logic              rd_who_reg, rd_who_next;
  logic              rd_blk_reg, rd_blk_next;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic [DATA_W-1:0] wdata_hold_reg;
  logic [DATA_W-1:0] rdata0_reg, rdata1_reg;

  logic              owner_keep, gnt0, gnt1, any_gnt;
  logic              sel_we, sel_lock, in_win;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, rd_data;

  // Grant selection: a locked owner keeps the port until its burst budget runs out under contention.
  always_comb begin
    owner_keep = 1'b0;
    case (owner_reg)
      OWN_M0:  owner_keep = m0_req && (!m1_req || burst_cnt_reg < BURST_LIM);
      OWN_M1:  owner_keep = m1_req && (!m0_req || burst_cnt_reg < BURST_LIM);
      default: owner_keep = 1'b0;
    endcase
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (owner_keep) begin
        gnt0 = (owner_reg == OWN_M0);
        gnt1 = (owner_reg == OWN_M1);
      end else if (m0_req && m1_req) begin
        gnt0 = rr_last_reg;
        gnt1 = !rr_last_reg;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  assign any_gnt   = gnt0 || gnt1;
  assign gnt_owner = gnt1 ? OWN_M1 : OWN_M0;
  assign sel_addr  = gnt1 ? m1_addr  : m0_addr;
  assign sel_wdata = gnt1 ? m1_wdata : m0_wdata;
  assign sel_we    = gnt1 ? m1_we    : m0_we;
  assign sel_lock  = gnt1 ? m1_lock  : m0_lock;
  assign in_win    = (sel_addr <= MEM_TOP);

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign mem_addr  = any_gnt ? sel_addr  : addr_hold_reg;
  assign mem_wdata = any_gnt ? sel_wdata : wdata_hold_reg;
  assign mem_we    = any_gnt && sel_we && in_win;

  assign rd_data   = rd_blk_reg ? '0 : mem_rdata;
  assign m0_rvalid = rd_pend_reg && !rd_who_reg;
  assign m1_rvalid = rd_pend_reg && rd_who_reg;
  assign m0_rdata  = m0_rvalid ? rd_data : rdata0_reg;
  assign m1_rdata  = m1_rvalid ? rd_data : rdata1_reg;

  always_comb begin
    owner_next     = owner_reg;
    burst_cnt_next = burst_cnt_reg;
    rr_last_next   = rr_last_reg;
    rd_pend_next   = 1'b0;
    rd_who_next    = rd_who_reg;
    rd_blk_next    = rd_blk_reg;
    // An owner that stops requesting gives up the lock.
    if ((owner_reg == OWN_M0 && !m0_req) || (owner_reg == OWN_M1 && !m1_req)) begin
      owner_next     = OWN_NONE;
      burst_cnt_next = 8'd0;
    end
    if (any_gnt) begin
      rr_last_next = gnt1;
      if (sel_lock) begin
        owner_next     = gnt_owner;
        burst_cnt_next = (owner_reg != gnt_owner) ? 8'd1 :
                         (burst_cnt_reg == 8'hff) ? 8'hff : burst_cnt_reg + 8'd1;
      end else begin
        owner_next     = OWN_NONE;
        burst_cnt_next = 8'd0;
      end
      if (!sel_we) begin
        rd_pend_next = 1'b1;
        rd_who_next  = gnt1;
        rd_blk_next  = !in_win;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg      <= OWN_NONE;
      burst_cnt_reg  <= 8'd0;
      rr_last_reg    <= 1'b1;
      rd_pend_reg    <= 1'b0;
      rd_who_reg     <= 1'b0;
      rd_blk_reg     <= 1'b0;
      addr_hold_reg  <= '0;
      wdata_hold_reg <= '0;
      rdata0_reg     <= '0;
      rdata1_reg     <= '0;
    end else begin
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
      rr_last_reg   <= rr_last_next;
      rd_pend_reg   <= rd_pend_next;
      rd_who_reg    <= rd_who_next;
      rd_blk_reg    <= rd_blk_next;
      if (any_gnt) begin
        addr_hold_reg  <= sel_addr;
        wdata_hold_reg <= sel_wdata;
      end
      if (m0_rvalid) rdata0_reg <= rd_data;
      if (m1_rvalid) rdata1_reg <= rd_data;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: a reference model predicts grants and port values;
// a monitor checks the returned read data against a shadow copy of the RAM.
module tb_mem_arbiter;
  localparam int MAXB = 4;
  localparam int TOP  = 'h0df;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [11:0] m0_addr = 0, m1_addr = 0, mem_addr;
  logic [15:0] m0_wdata = 0, m1_wdata = 0, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;

  mem_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_TOP(12'h0df), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM attached to the arbiter: registered read, full 4K so blocked addresses hold live data.
  logic [15:0] ram [4096];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int who; logic [15:0] data; int cyc;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  // Reference model state: who won last, who holds a lock, how many grants in the current streak.
  logic [15:0] shadow [4096];
  int          last_win, holder, streak;
  logic [11:0] addr_hold;
  logic        req[2], we[2], lk[2];
  logic [11:0] addr[2];
  logic [15:0] wd[2];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick();
    if (holder >= 0 && req[holder] && (!req[1-holder] || streak < MAXB)) return holder;
    if (req[0] && req[1]) return 1 - last_win;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    last_win = 1; holder = -1; streak = 0; addr_hold = '0;
  endtask

  task automatic drive(int m, logic r, logic w, logic l, int a, int d);
    req[m] = r; we[m] = w; lk[m] = l; addr[m] = 12'(a); wd[m] = 16'(d);
  endtask

  task automatic idle_ports();
    m0_req = 0; m1_req = 0; req[0] = 0; req[1] = 0;
  endtask

  task automatic step();
    int w;
    @(negedge clk);
    m0_req = req[0]; m0_we = we[0]; m0_lock = lk[0]; m0_addr = addr[0]; m0_wdata = wd[0];
    m1_req = req[1]; m1_we = we[1]; m1_lock = lk[1]; m1_addr = addr[1]; m1_wdata = wd[1];
    #1;
    w = pick();
    check("m0_gnt", m0_gnt, w == 0);
    check("m1_gnt", m1_gnt, w == 1);
    if (w >= 0) begin
      check("mem_addr", mem_addr, addr[w]);
      check("mem_wdata", mem_wdata, wd[w]);
      check("mem_we", mem_we, we[w] && addr[w] <= TOP);
      if (we[w]) begin
        if (addr[w] <= TOP) shadow[addr[w]] = wd[w];
      end else begin
        q.push_back('{who: w, data: (addr[w] <= TOP) ? shadow[addr[w]] : 16'h0, cyc: cyc + 1});
      end
      addr_hold = addr[w];
    end else begin
      check("mem_we_idle", mem_we, 0);
      check("mem_addr_hold", mem_addr, addr_hold);
    end
    if (holder >= 0 && !req[holder]) begin holder = -1; streak = 0; end
    if (w >= 0) begin
      last_win = w;
      if (lk[w]) begin
        streak = (holder == w) ? ((streak < 255) ? streak + 1 : 255) : 1;
        holder = w;
      end else begin
        holder = -1; streak = 0;
      end
    end
  endtask

  // Reset is asserted between a grant and the following edge, so any pending read must vanish.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("rst_gnt", {m1_gnt, m0_gnt}, 0);
    check("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", {m1_rdata, m0_rdata}, 0);
    repeat (2) @(negedge clk);
    idle_ports();
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: pops the expected read return when it falls due and checks rvalid/rdata every cycle.
  logic [15:0] hold0 = 0, hold1 = 0;
  initial begin
    exp_t e;
    logic [1:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        hold0 = 0; hold1 = 0;
        check("rvalid_in_reset", {m1_rvalid, m0_rvalid}, 0);
      end else begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          check("missed_rvalid", 0, 1);
        end
        exp_v = 2'b00;
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          exp_v = (e.who == 1) ? 2'b10 : 2'b01;
          if (e.who == 1) hold1 = e.data; else hold0 = e.data;
        end
        check("rvalid", {m1_rvalid, m0_rvalid}, exp_v);
        check("m0_rdata", m0_rdata, hold0);
        check("m1_rdata", m1_rdata, hold1);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 16'(i * 37 + 16'h5a5);
      shadow[i] = 16'(i * 37 + 16'h5a5);
    end
    ram[16] = 16'h1234; shadow[16] = 16'h1234;
    for (int m = 0; m < 2; m++) drive(m, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check("reset_gnt", {m1_gnt, m0_gnt}, 0);
    check("reset_rvalid", {m1_rvalid, m0_rvalid}, 0);
    check("reset_mem", {mem_we, mem_addr, mem_wdata}, 0);
    check("reset_rdata", {m1_rdata, m0_rdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single read of a preloaded word.
    drive(0, 1, 0, 0, 'h010, 0); step();
    drive(0, 0, 0, 0, 0, 0); repeat (2) step();
    // Contended unlocked reads alternate.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 0, $urandom_range(0, 255), 0);
      drive(1, 1, 0, 0, $urandom_range(0, 255), 0);
      step();
    end
    // m1 bursts with lock while m0 waits, then m1 alone keeps the port.
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 0, 0, $urandom_range(0, 255), 0);
      drive(1, 1, 0, 1, $urandom_range(0, 255), 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin drive(1, 1, 0, 1, $urandom_range(0, 255), 0); step(); end
    drive(1, 0, 0, 0, 0, 0); step();
    // Blocked write then blocked read.
    drive(0, 1, 1, 0, 'h0e5, 'hbeef); step();
    drive(0, 1, 0, 0, 'h0e5, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    // Write by m0 then read-after-write by m1.
    drive(0, 1, 1, 0, 'h020, 'haaaa); step();
    drive(0, 0, 0, 0, 0, 0); drive(1, 1, 0, 0, 'h020, 0); step();
    drive(1, 0, 0, 0, 0, 0); repeat (2) step();
    // Reset while m1 holds a lock with a read just granted.
    drive(1, 1, 0, 1, 'h030, 0); step();
    drive(0, 1, 0, 0, 'h040, 0); step();
    do_reset();
    drive(0, 1, 0, 0, 'h050, 0); drive(1, 1, 0, 0, 'h060, 0); step();
    repeat (2) step();
    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      for (int m = 0; m < 2; m++) begin
        drive(m, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 255),
              $urandom_range(0, 65535));
      end
      step();
    end
    drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
    repeat (3) step();
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master arbiter sharing the single-port program/data RAM (16-bit words, 12-bit word address) between the CPU (master 0) and a display/DMA fetch engine (master 1). It grants one access per cycle, drives the RAM port from the granted master, and returns read data to that master one cycle later with a valid strobe. Fairness is round-robin. A lock input lets a master hold the port for a bounded burst. Out-of-window accesses are blocked.

Parameters:
ADDR_W, 12, word address width of both masters and the RAM port
DATA_W, 16, data width
MEM_TOP, 12'h0df, highest RAM address; accesses above it are blocked (no write, read returns 0)
MAX_BURST, 8, maximum consecutive grants to a locking master while the other master is requesting (range 1..255)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  master 0 (CPU) access request, held until granted
m0_we  in  1  master 0 write enable (1 = write)
m0_lock  in  1  master 0 burst lock, keep port after this grant
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_gnt  out  1  master 0 access accepted this cycle
m0_rvalid  out  1  master 0 read data valid (one cycle after read grant)
m0_rdata  out  DATA_W  master 0 read data
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, registered, valid the cycle after the address

Behaviour:
- Reset (async, rst_n=0): rr_last=1 (master 0 wins first tie), owner=none, burst_cnt=0, rd_pend=0, rd_who=0, rd_blk=0; all gnt/rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0. Reset mid-burst or mid-read drops the pending rvalid with no later pulse.
- Grant is combinational from req and registered state: at most one gnt per cycle, never both.
- Arbitration, in order:
  - locked owner with its req=1 and (other req=0 or burst_cnt<MAX_BURST) -> owner granted
  - only one req -> that master
  - both req -> master != rr_last
  - no req -> no grant, mem_we=0, mem_addr holds last value
- On grant to master k: mem_addr=mk_addr, mem_wdata=mk_wdata, mem_we=mk_we AND (mk_addr<=MEM_TOP); rr_last<=k.
- Lock: if mk_lock=1 at grant, owner<=k and burst_cnt<=burst_cnt+1 (saturating at 255; reset to 1 when the owner changes). If mk_lock=0 at grant, or the owner has req=0, owner<=none and burst_cnt<=0.
- Forced release: when burst_cnt==MAX_BURST and the other master is requesting, the other master gets the next grant and ownership clears, even if lock is still 1.
- Read return: a read grant sets rd_pend<=1 and rd_who<=k, and records blocked<=(addr>MEM_TOP). Next cycle mk_rvalid=1 for one cycle and mk_rdata=mem_rdata, or 0 if blocked. rdata holds its value between pulses. Back-to-back reads give back-to-back rvalid pulses in grant order.
- Write grants produce no rvalid. Blocked writes still assert gnt (the request completes) but mem_we stays 0.
- A master that drops req before its grant loses nothing; no state is kept for ungranted requests.

Test Plan:
- Reset, then m0_req read addr 0x010 (RAM=0x1234) -> m0_gnt same cycle, m0_rvalid=1 and m0_rdata=0x1234 next cycle; m1 outputs stay 0.
- Both req continuously, unlocked reads -> grants alternate 0,1,0,1; first grant goes to m0 after reset.
- m1 lock=1 with continuous req, m0 req from cycle 0, MAX_BURST=4 -> m1 gets 4 consecutive grants, then m0 granted; with m0 idle, m1 holds the port indefinitely.
- m0 write addr 0x0e5 data 0xBEEF -> m0_gnt=1, mem_we=0, RAM unchanged; read of 0x0e5 -> rvalid with rdata=0x0000.
- m0 write 0x020=0xAAAA, then m1 read 0x020 next cycle -> m1_rdata=0xAAAA, m1_rvalid one cycle after its grant.
- Pulse rst_n low while m1 is locked with a read pending -> outputs clear immediately; no rvalid after release; first grant after reset goes to m0.
